// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared line geometry, adapter state type and address mask
package cache_pkg;

  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int BEATS      = 4;
  localparam int LINE_BYTES = LINE_W / 8;

  localparam logic [31:0] LINE_ADDR_MASK = ~(32'(LINE_BYTES) - 32'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } cla_state_e;

endpackage

// File: rtl/burst_shreg.sv
// rtl/burst_shreg.sv - beat indexer: assembles read beats into line_o, slices the latched write line
module burst_shreg
  import cache_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [BURST_W*BEATS-1:0] line_i,
  input  logic                     capture,
  input  logic [CNT_W-1:0]         beat,
  input  logic [BURST_W-1:0]       burst_i,
  output logic [BURST_W*BEATS-1:0] line_o,
  output logic [BURST_W-1:0]       burst_o
);

  logic [BURST_W*BEATS-1:0] wr_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_line <= '0;
      line_o  <= '0;
    end else begin
      if (load)
        wr_line <= line_i;
      if (capture)
        line_o[beat*BURST_W +: BURST_W] <= burst_i;
    end
  end

  // write beat follows the counter directly so it is valid the cycle the burst opens
  assign burst_o = wr_line[beat*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - cache line <-> 64-bit burst memory adapter; CLA_PROTOCOL_ERR_EN adds err output
module cacheline_adapter
  import cache_pkg::*;
#(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        address_i,
  input  logic                     read_i,
  input  logic                     write_i,
  input  logic [BURST_W*BEATS-1:0] line_i,
  output logic [BURST_W*BEATS-1:0] line_o,
  output logic                     resp_o,
  output logic [ADDR_W-1:0]        address_o,
  output logic                     read_o,
  output logic                     write_o,
  input  logic [BURST_W-1:0]       burst_i,
  output logic [BURST_W-1:0]       burst_o,
  input  logic                     resp_i
`ifdef CLA_PROTOCOL_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(8 * BEATS);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  cla_state_e       state;
  logic [CNT_W-1:0] beat;
  logic             load;
  logic             capture;

  assign load    = (state == IDLE) && write_i;
  assign capture = (state == RD_BURST) && resp_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            state     <= WR_BURST;
            write_o   <= 1'b1;
            address_o <= address_i & ADDR_MASK;
            beat      <= '0;
          end else if (read_i) begin
            state     <= RD_BURST;
            read_o    <= 1'b1;
            address_o <= address_i & ADDR_MASK;
            beat      <= '0;
          end
        end
        RD_BURST, WR_BURST: begin
          if (resp_i) begin
            // counter parks on the last beat instead of wrapping
            if (beat == LAST_BEAT) begin
              state   <= DONE;
              read_o  <= 1'b0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
            end else begin
              beat <= beat + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          resp_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  burst_shreg #(
    .BEATS (BEATS),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .line_i  (line_i),
    .capture (capture),
    .beat    (beat),
    .burst_i (burst_i),
    .line_o  (line_o),
    .burst_o (burst_o)
  );

`ifdef CLA_PROTOCOL_ERR_EN
  logic dropped;

  // a dropped request is reported once per burst, not every cycle it stays low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err     <= 1'b0;
      dropped <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          dropped <= 1'b0;
          if (read_i && write_i)
            err <= 1'b1;
        end
        RD_BURST: if (!read_i && !dropped) begin
          err     <= 1'b1;
          dropped <= 1'b1;
        end
        WR_BURST: if (!write_i && !dropped) begin
          err     <= 1'b1;
          dropped <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - scoreboard bench for cacheline_adapter with a random memory responder
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         resp_i;
`ifdef CLA_PROTOCOL_ERR_EN
  logic         err;
`endif

  cacheline_adapter #(.BEATS(4), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_i    (resp_i)
`ifdef CLA_PROTOCOL_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
    int           lat;
    int           issue;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  rd_beats_q[$];
  logic [63:0]  wr_beats_q[$];
  logic [255:0] shadow = '0;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           gap_lo = 0, gap_hi = 0;
  bit           stray = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // memory side: random gap before each beat, supplies read beats, checks write beats
  initial begin : responder
    int gap_cnt;
    gap_cnt = -1;
    resp_i  = 1'b0;
    burst_i = '0;
    forever begin
      @(negedge clk);
      resp_i = 1'b0;
      if (!rst) begin
        gap_cnt = -1;
      end else if (read_o || write_o) begin
        if (write_o && wr_beats_q.size() > 0)
          chk("burst_o_hold", burst_o, wr_beats_q[0]);
        if (gap_cnt < 0)
          gap_cnt = $urandom_range(gap_hi, gap_lo);
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          gap_cnt = -1;
          if (read_o) begin
            if (rd_beats_q.size() == 0) begin
              chk("read_o_after_last", read_o, 1'b0);
            end else begin
              burst_i = rd_beats_q.pop_front();
              resp_i  = 1'b1;
            end
          end else begin
            if (wr_beats_q.size() == 0) begin
              chk("write_o_after_last", write_o, 1'b0);
            end else begin
              chk("burst_o_beat", burst_o, wr_beats_q.pop_front());
              resp_i = 1'b1;
            end
          end
        end
      end else begin
        gap_cnt = -1;
        if (stray) resp_i = 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit   pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("resp_one_cycle", resp_o, 1'b0);
        pend = 0;
      end
      if (rst && resp_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", resp_o, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("address_o", address_o, e.addr);
          chk("line_o", line_o, e.line);
          if (e.lat >= 0)
            chk("latency", cyc - e.issue + 2, e.lat);
          pend = 1;
        end
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] line, input int glo, input int ghi, input bit drop);
    exp_t e;
    bit   seen;
    @(negedge clk);
    gap_lo = glo;
    gap_hi = ghi;
    for (int k = 0; k < 4; k++) begin
      if (wr) wr_beats_q.push_back(line[64*k +: 64]);
      else    rd_beats_q.push_back(line[64*k +: 64]);
    end
    if (!wr) shadow = line;
    e.addr  = addr & 32'hFFFF_FFE0;
    e.line  = shadow;
    e.lat   = (ghi == 0) ? 6 : -1;
    e.issue = cyc + 1;
    exp_q.push_back(e);
    address_i = addr;
    line_i    = line;
    read_i    = rd;
    write_i   = wr;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
`ifdef CLA_PROTOCOL_ERR_EN
      if (i == 0) chk("err_both_high", err, rd && wr);
`endif
      if (drop && i == 0) begin
        read_i  = 1'b0;
        write_i = 1'b0;
      end
      if (resp_o) seen = 1;
    end
    chk("resp_timeout", seen, 1'b1);
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [255:0] pat;
    bit           ok;
    rst       = 1'b0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    repeat (3) @(negedge clk);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_address_o", address_o, '0);
    chk("rst_line_o", line_o, '0);
    chk("rst_burst_o", burst_o, '0);
    rst = 1'b1;

    do_req(1, 0, 32'h0000_1234,
           {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}}, 0, 0, 0);
    for (int k = 0; k < 4; k++) pat[64*k +: 64] = {32'hDEAD_0000 | k, 32'hBEEF_0000 | k};
    do_req(0, 1, 32'h0000_5678, pat, 0, 0, 0);
    do_req(1, 1, 32'hABCD_EF01, rand_line(), 0, 0, 0);
    do_req(1, 0, 32'h1000_003F, rand_line(), 3, 3, 0);
    do_req(0, 1, 32'h2000_0020, rand_line(), 3, 3, 0);

    @(negedge clk);
    stray = 1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_read_o", read_o, 1'b0);
      chk("stray_write_o", write_o, 1'b0);
      chk("stray_resp_o", resp_o, 1'b0);
    end
    stray = 0;

    do_req(1, 0, 32'h3000_0044, rand_line(), 0, 1, 1);
    do_req(0, 1, 32'h4000_0088, rand_line(), 0, 2, 1);

    // reset in the middle of a read, after beat 2 has been captured
    @(negedge clk);
    gap_lo = 2;
    gap_hi = 2;
    pat = rand_line();
    for (int k = 0; k < 4; k++) rd_beats_q.push_back(pat[64*k +: 64]);
    address_i = 32'h5000_0000;
    read_i    = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rd_beats_q.size() == 1) ok = 1;
    end
    chk("mid_reset_reach_beat2", ok, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_read_o", read_o, 1'b0);
    chk("mid_rst_resp_o", resp_o, 1'b0);
    chk("mid_rst_address_o", address_o, '0);
    chk("mid_rst_line_o", line_o, '0);
    chk("mid_rst_burst_o", burst_o, '0);
    rd_beats_q.delete();
    read_i = 1'b0;
    shadow = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_resp_o", resp_o, 1'b0);
      chk("post_rst_read_o", read_o, 1'b0);
    end
    do_req(1, 0, 32'h6000_1234, rand_line(), 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      int op;
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, $urandom, rand_line(), 0,
             $urandom_range(0, 3), $urandom_range(0, 4) == 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameters: BEATS, default 4, number of 64-bit beats per line; ADDR_W, default 32, address width.
REQ-002 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: address_i  input  ADDR_W  line request address from eviction write buffer side.
REQ-005 SHALL have ports: read_i  input  1  line read request, held until resp_o.
REQ-006 SHALL have ports: write_i  input  1  line write request, held until resp_o.
REQ-007 SHALL have ports: line_i  input  64*BEATS  line write data; line_o  output  64*BEATS  assembled read line.
REQ-008 SHALL have ports: resp_o  output  1  one-cycle completion pulse to requester.
REQ-009 SHALL have ports: address_o  output  ADDR_W  line-aligned memory address; read_o, write_o  output  1  burst request strobes.
REQ-010 SHALL have ports: burst_i  input  64  read beat; burst_o  output  64  write beat; resp_i  input  1  per-beat memory acknowledge.

Function
REQ-011 SHALL implement states IDLE, RD_BURST, WR_BURST, DONE.
REQ-012 In IDLE, write_i SHALL take priority over read_i; the adapter SHALL go to WR_BURST on write_i, else to RD_BURST on read_i.
REQ-013 On leaving IDLE, the adapter SHALL latch address_i with the low log2(8*BEATS) bits zeroed into address_o, latch line_i on writes, and clear the beat counter.
REQ-014 In RD_BURST, read_o SHALL be 1; on each resp_i, burst_i SHALL be written to line_o bits [64k+63:64k] for beat k, and k SHALL increment.
REQ-015 In WR_BURST, write_o SHALL be 1 and burst_o SHALL equal latched-line beat k; each resp_i SHALL increment k.
REQ-016 After resp_i on beat BEATS-1, the next state SHALL be DONE; read_o/write_o SHALL deassert in that same next cycle.
REQ-017 DONE SHALL assert resp_o for exactly one cycle and return to IDLE; new requests SHALL be sampled only in IDLE, at the earliest one cycle after DONE.
REQ-018 Request latency SHALL be BEATS resp_i cycles + 2 (1 accept cycle + 1 DONE cycle).
REQ-019 read_i/write_i deasserted mid-burst SHALL NOT abort; the burst SHALL complete and resp_o SHALL still pulse.
REQ-020 resp_i while in IDLE or DONE SHALL be ignored.
REQ-021 line_o SHALL hold its value until overwritten by a subsequent read burst; write bursts SHALL NOT alter line_o.
REQ-022 The beat counter SHALL be ceil(log2(BEATS)) bits wide and SHALL never wrap within a burst.

Reset
REQ-023 On rst low, asynchronously: state=IDLE, resp_o=0, read_o=0, write_o=0, address_o=0, line_o=0, burst_o=0, counter=0.
REQ-024 Reset mid-burst SHALL abandon the burst with no resp_o; after release, the adapter SHALL be in IDLE.

Configuration
REQ-025 Macro CLA_PROTOCOL_ERR_EN, when defined, SHALL add output err (1 bit, reset 0) that pulses one cycle on: read_i and write_i both high in IDLE, or the active request dropping before DONE.
REQ-026 Without CLA_PROTOCOL_ERR_EN, the err port SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-027 Package cache_pkg SHALL hold: LINE_W=256, BURST_W=64, BEATS=4, the adapter state enum type, and a line-address mask constant.
REQ-028 A sub-module burst_shreg (beat indexer/assembler for line_o and burst_o) SHALL be used; the FSM stays in cacheline_adapter.

Verification
REQ-029 Read: address_i=0x0000_1234, read_i=1, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, one resp_o pulse 6 cycles after accept with no stalls.
REQ-030 Write: line_i=0xDEAD..BEEF pattern, write_i=1 -> burst_o beats in order 0..3 on successive resp_i, write_o drops after beat 3, one resp_o pulse, line_o unchanged.
REQ-031 Simultaneous read_i=write_i=1 in IDLE -> WR_BURST taken; with CLA_PROTOCOL_ERR_EN, err=1 for one cycle.
REQ-032 resp_i stalls (gaps of 3 cycles between beats) -> k advances only on resp_i; resp_o still one pulse; stray resp_i in IDLE -> no state change.
REQ-033 rst asserted after beat 2 of a read -> all outputs zero immediately, no resp_o; a following read completes normally.
